// File: rtl/mips_cpu_pkg.sv
// Shared encodings for the MIPS multicycle sequencer and its control decoder:
// sequencer states, opcode/func_code values and the instruction classes the sequencer steps on.
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH         = 3'd0,
        ST_DECODE        = 3'd1,
        ST_EXECUTE       = 3'd2,
        ST_MEMORY_ACCESS = 3'd3,
        ST_WRITE_BACK    = 3'd4,
        ST_HALT          = 3'b101
    } state_t;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LB    = 6'h20,
        OP_LWL   = 6'h22,
        OP_LW    = 6'h23,
        OP_SB    = 6'h28,
        OP_SW    = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL   = 6'h00,
        FN_SRL   = 6'h02,
        FN_SRA   = 6'h03,
        FN_SLLV  = 6'h04,
        FN_SRLV  = 6'h06,
        FN_SRAV  = 6'h07,
        FN_JR    = 6'h08,
        FN_MULT  = 6'h18,
        FN_MULTU = 6'h19,
        FN_DIV   = 6'h1A,
        FN_DIVU  = 6'h1B,
        FN_ADDU  = 6'h21,
        FN_SUBU  = 6'h23,
        FN_AND   = 6'h24,
        FN_OR    = 6'h25,
        FN_XOR   = 6'h26,
        FN_SLT   = 6'h2A,
        FN_SLTU  = 6'h2B
    } func_t;

    typedef enum logic [2:0] {
        CLS_NOP    = 3'd0,
        CLS_ALU    = 3'd1,
        CLS_MULDIV = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4
    } instr_class_t;

    // JR lands in CLS_ALU: it needs the same one-cycle MEMORY_ACCESS slot for the PC update.
    function automatic instr_class_t classify(input logic [5:0] opcode, input logic [5:0] func_code);
        instr_class_t cls;
        cls = CLS_NOP;
        case (opcode)
            OP_RTYPE: begin
                case (func_code)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_JR,
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_SLT, FN_SLTU:
                        cls = CLS_ALU;
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:
                        cls = CLS_MULDIV;
                    default:
                        cls = CLS_NOP;
                endcase
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: cls = CLS_ALU;
            OP_LB, OP_LWL, OP_LW:                                  cls = CLS_LOAD;
            OP_SB, OP_SW:                                          cls = CLS_STORE;
            default:                                               cls = CLS_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mips_state_sequencer_watchdog.sv
// Stall watchdog: down-counter reloaded whenever the sequencer is not stalling, trips on the
// STALL_LIMIT-th consecutive stall cycle. STALL_LIMIT=0 disables it.
module seq_stall_watchdog #(
    parameter int STALL_LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic stall,
    output logic trip
);

    localparam int CNT_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
    localparam logic [CNT_W-1:0] RELOAD = (STALL_LIMIT > 0) ? CNT_W'(STALL_LIMIT - 1) : '0;

    logic [CNT_W-1:0] remaining_q;

    always_ff @(posedge clk) begin
        if (reset || !stall) begin
            remaining_q <= RELOAD;
        end else if (remaining_q != '0) begin
            remaining_q <= remaining_q - 1'b1;
        end
    end

    assign trip = (STALL_LIMIT != 0) && stall && (remaining_q == '0);

endmodule

// File: rtl/mips_state_sequencer.sv
// Multicycle state sequencer for the MIPS CPU; drives the 3-bit state into the control decoder.
// Optional perf counters (instr_retired, cycle_count) are built when SEQ_PERF_COUNT_EN is defined.
//
// state            | meaning
// FETCH            | instruction read, holds on waitrequest
// DECODE           | IR loads, always one cycle
// EXECUTE          | ALU op; holds while a MULT/DIV is busy
// MEMORY_ACCESS    | load/store (holds on waitrequest) or ALU/JR reg write / PC update
// WRITE_BACK       | load result to register file
// HALT             | sticky until reset; jump to 0 or watchdog fault
module mips_state_sequencer
    import mips_cpu_pkg::*;
#(
    parameter int STALL_LIMIT = 1024
`ifdef SEQ_PERF_COUNT_EN
    ,
    parameter int COUNT_W = 32
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func_code,
    input  logic               waitrequest,
    input  logic               alu_busy,
    input  logic               pc_is_zero,
    output logic [2:0]         state,
    output logic               active,
`ifdef SEQ_PERF_COUNT_EN
    output logic               fault,
    output logic [COUNT_W-1:0] instr_retired,
    output logic [COUNT_W-1:0] cycle_count
`else
    output logic               fault
`endif
);

    state_t       state_q, state_d;
    instr_class_t cls;
    logic         retire;
    logic         stall;
    logic         wd_trip;
    logic         fault_q;

    assign cls = classify(opcode, func_code);

    seq_stall_watchdog #(
        .STALL_LIMIT(STALL_LIMIT)
    ) u_watchdog (
        .clk  (clk),
        .reset(reset),
        .stall(stall),
        .trip (wd_trip)
    );

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        stall   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (waitrequest) stall = 1'b1;
                else             state_d = ST_DECODE;
            end
            ST_DECODE: state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                case (cls)
                    CLS_ALU, CLS_LOAD, CLS_STORE: state_d = ST_MEMORY_ACCESS;
                    CLS_MULDIV:                   retire  = !alu_busy;
                    default:                      retire  = 1'b1;
                endcase
            end
            ST_MEMORY_ACCESS: begin
                case (cls)
                    CLS_LOAD: begin
                        if (waitrequest) stall = 1'b1;
                        else             state_d = ST_WRITE_BACK;
                    end
                    CLS_STORE: begin
                        if (waitrequest) stall  = 1'b1;
                        else             retire = 1'b1;
                    end
                    default: retire = 1'b1;
                endcase
            end
            ST_WRITE_BACK: retire = 1'b1;
            ST_HALT:       state_d = ST_HALT;
            default:       state_d = ST_FETCH;
        endcase
        // A retire edge with PC==0 is a jump/return to address 0: stop the CPU instead of fetching.
        if (retire)  state_d = pc_is_zero ? ST_HALT : ST_FETCH;
        if (wd_trip) state_d = ST_HALT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wd_trip) fault_q <= 1'b1;
        end
    end

    assign state  = state_q;
    assign active = (state_q != ST_HALT);
    assign fault  = fault_q;

`ifdef SEQ_PERF_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_retired <= '0;
            cycle_count   <= '0;
        end else if (state_q != ST_HALT) begin
            cycle_count <= cycle_count + COUNT_W'(1);
            if (retire) instr_retired <= instr_retired + COUNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mips_state_sequencer.sv
// Bench for mips_state_sequencer: each instruction is planned as a per-cycle list of expected
// states derived from its class and the chosen stall lengths, then replayed against the DUT.
module tb_mips_state_sequencer;

    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2,
                           S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;
    localparam int C_NOP = 0, C_ALU = 1, C_MULDIV = 2, C_LOAD = 3, C_STORE = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] func_code = '0;
    logic       waitrequest = 1'b0;
    logic       alu_busy = 1'b0;
    logic       pc_is_zero = 1'b0;
    logic [2:0] state;
    logic       active;
    logic       fault;
`ifdef SEQ_PERF_COUNT_EN
    logic [31:0] instr_retired;
    logic [31:0] cycle_count;
`endif

    int vectors = 0;
    int miscompares = 0;
    int unsigned mdl_retired = 0;
    int unsigned mdl_cycles = 0;

    mips_state_sequencer #(
        .STALL_LIMIT(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .func_code  (func_code),
        .waitrequest(waitrequest),
        .alu_busy   (alu_busy),
        .pc_is_zero (pc_is_zero),
        .state      (state),
        .active     (active),
`ifdef SEQ_PERF_COUNT_EN
        .fault        (fault),
        .instr_retired(instr_retired),
        .cycle_count  (cycle_count)
`else
        .fault      (fault)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic int ref_class(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            if (fn inside {6'h21, 6'h24, 6'h25, 6'h26, 6'h23, 6'h2A, 6'h2B,
                           6'h00, 6'h04, 6'h02, 6'h06, 6'h03, 6'h07, 6'h08}) return C_ALU;
            if (fn inside {6'h18, 6'h19, 6'h1A, 6'h1B}) return C_MULDIV;
            return C_NOP;
        end
        if (op inside {6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E}) return C_ALU;
        if (op inside {6'h23, 6'h20, 6'h22}) return C_LOAD;
        if (op inside {6'h2B, 6'h28}) return C_STORE;
        return C_NOP;
    endfunction

    // Drives reset across one edge; leaves the bench at a falling edge with reset low.
    task automatic apply_reset();
        reset = 1'b1;
        waitrequest = rbit();
        alu_busy = rbit();
        pc_is_zero = rbit();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mdl_retired = 0;
        mdl_cycles = 0;
    endtask

    // fw/mw: waitrequest cycles in FETCH / MEMORY_ACCESS, bz: alu_busy cycles, pcz: PC==0 at retire.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                             input int bz, input logic pcz, input string tag);
        logic [2:0] q_st[$];
        logic       q_wr[$];
        logic       q_bz[$];
        int         cls;
        int         n;
        cls = ref_class(op, fn);
        for (int i = 0; i < fw; i++) begin
            q_st.push_back(S_FETCH); q_wr.push_back(1'b1); q_bz.push_back(rbit());
        end
        q_st.push_back(S_FETCH);  q_wr.push_back(1'b0);   q_bz.push_back(rbit());
        q_st.push_back(S_DECODE); q_wr.push_back(rbit()); q_bz.push_back(rbit());
        if (cls == C_MULDIV) begin
            for (int i = 0; i < bz; i++) begin
                q_st.push_back(S_EXECUTE); q_wr.push_back(rbit()); q_bz.push_back(1'b1);
            end
            q_st.push_back(S_EXECUTE); q_wr.push_back(rbit()); q_bz.push_back(1'b0);
        end else begin
            q_st.push_back(S_EXECUTE); q_wr.push_back(rbit()); q_bz.push_back(rbit());
        end
        if (cls == C_LOAD || cls == C_STORE) begin
            for (int i = 0; i < mw; i++) begin
                q_st.push_back(S_MEM); q_wr.push_back(1'b1); q_bz.push_back(rbit());
            end
            q_st.push_back(S_MEM); q_wr.push_back(1'b0); q_bz.push_back(rbit());
        end else if (cls == C_ALU) begin
            q_st.push_back(S_MEM); q_wr.push_back(rbit()); q_bz.push_back(rbit());
        end
        if (cls == C_LOAD) begin
            q_st.push_back(S_WB); q_wr.push_back(rbit()); q_bz.push_back(rbit());
        end
        n = q_st.size();
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (state !== q_st[i] || active !== 1'b1) begin
                miscompares++;
                $display("FAIL %s cycle %0d: state=%0d active=%b, expected state=%0d active=1",
                         tag, i, state, active, q_st[i]);
            end
            // IR is only valid from EXECUTE on; garbage before that must not matter.
            opcode      = (q_st[i] >= S_EXECUTE) ? op : 6'($urandom);
            func_code   = (q_st[i] >= S_EXECUTE) ? fn : 6'($urandom);
            waitrequest = q_wr[i];
            alu_busy    = q_bz[i];
            pc_is_zero  = (i == n - 1) ? pcz : rbit();
            @(posedge clk);
            @(negedge clk);
        end
        mdl_retired++;
        mdl_cycles += n;
        vectors++;
        if (state !== (pcz ? S_HALT : S_FETCH) || active !== !pcz || fault !== 1'b0) begin
            miscompares++;
            $display("FAIL %s end: state=%0d active=%b fault=%b, expected state=%0d active=%b fault=0",
                     tag, state, active, fault, pcz ? S_HALT : S_FETCH, !pcz);
        end
`ifdef SEQ_PERF_COUNT_EN
        vectors++;
        if (instr_retired !== 32'(mdl_retired) || cycle_count !== 32'(mdl_cycles)) begin
            miscompares++;
            $display("FAIL %s counters: retired=%0d cycles=%0d, expected retired=%0d cycles=%0d",
                     tag, instr_retired, cycle_count, mdl_retired, mdl_cycles);
        end
`endif
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (state !== S_FETCH || active !== 1'b1 || fault !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: state=%0d active=%b fault=%b, expected 0 1 0", state, active, fault);
        end
`ifdef SEQ_PERF_COUNT_EN
        vectors++;
        if (instr_retired !== 32'd0 || cycle_count !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_counters: retired=%0d cycles=%0d, expected 0 0", instr_retired, cycle_count);
        end
`endif
    endtask

    task automatic test_directed();
        run_instr(6'h00, 6'h21, 0, 0, 0, 1'b0, "addu");
        run_instr(6'h23, 6'h15, 0, 3, 0, 1'b0, "lw_stall3");
        run_instr(6'h00, 6'h1A, 0, 0, 32, 1'b0, "div_busy32");
        run_instr(6'h2B, 6'h00, 2, 2, 0, 1'b0, "sw_stall");
        run_instr(6'h0D, 6'h3F, 7, 0, 0, 1'b0, "ori_fetch7");
        run_instr(6'h22, 6'h00, 0, 7, 0, 1'b0, "lwl_mem7");
        run_instr(6'h00, 6'h3F, 0, 0, 0, 1'b0, "rtype_nop");
        run_instr(6'h00, 6'h18, 0, 0, 0, 1'b0, "mult_nobusy");
    endtask

    task automatic test_jr_halt();
        run_instr(6'h00, 6'h08, 0, 0, 0, 1'b1, "jr_zero");
        for (int i = 0; i < 6; i++) begin
            waitrequest = rbit();
            alu_busy = rbit();
            pc_is_zero = rbit();
            opcode = 6'($urandom);
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (state !== S_HALT || active !== 1'b0 || fault !== 1'b0) begin
                miscompares++;
                $display("FAIL halt_sticky %0d: state=%0d active=%b fault=%b, expected 5 0 0",
                         i, state, active, fault);
            end
        end
`ifdef SEQ_PERF_COUNT_EN
        vectors++;
        if (instr_retired !== 32'(mdl_retired) || cycle_count !== 32'(mdl_cycles)) begin
            miscompares++;
            $display("FAIL halt_frozen: retired=%0d cycles=%0d, expected %0d %0d",
                     instr_retired, cycle_count, mdl_retired, mdl_cycles);
        end
`endif
        apply_reset();
        vectors++;
        if (state !== S_FETCH || active !== 1'b1 || fault !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_reset: state=%0d active=%b fault=%b, expected 0 1 0", state, active, fault);
        end
    endtask

    task automatic test_watchdog();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (state !== S_FETCH || fault !== 1'b0) begin
                miscompares++;
                $display("FAIL wd_hold %0d: state=%0d fault=%b, expected 0 0", i, state, fault);
            end
            waitrequest = 1'b1;
            pc_is_zero = rbit();
            @(posedge clk);
            @(negedge clk);
        end
        vectors++;
        if (state !== S_HALT || active !== 1'b0 || fault !== 1'b1) begin
            miscompares++;
            $display("FAIL wd_trip: state=%0d active=%b fault=%b, expected 5 0 1", state, active, fault);
        end
`ifdef SEQ_PERF_COUNT_EN
        vectors++;
        if (instr_retired !== 32'd0 || cycle_count !== 32'd8) begin
            miscompares++;
            $display("FAIL wd_counters: retired=%0d cycles=%0d, expected 0 8", instr_retired, cycle_count);
        end
`endif
        waitrequest = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (state !== S_HALT || fault !== 1'b1) begin
            miscompares++;
            $display("FAIL wd_sticky: state=%0d fault=%b, expected 5 1", state, fault);
        end
        apply_reset();
        vectors++;
        if (state !== S_FETCH || active !== 1'b1 || fault !== 1'b0) begin
            miscompares++;
            $display("FAIL wd_reset: state=%0d active=%b fault=%b, expected 0 1 0", state, active, fault);
        end
    endtask

    task automatic test_reset_mid_lw();
        run_instr(6'h0C, 6'h00, 1, 0, 0, 1'b0, "andi_pre");
        opcode = 6'h23;
        func_code = 6'h00;
        waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        waitrequest = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (state !== S_MEM) begin
            miscompares++;
            $display("FAIL mid_lw_setup: state=%0d, expected 3", state);
        end
        apply_reset();
        vectors++;
        if (state !== S_FETCH || active !== 1'b1 || fault !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_lw_reset: state=%0d active=%b fault=%b, expected 0 1 0", state, active, fault);
        end
`ifdef SEQ_PERF_COUNT_EN
        vectors++;
        if (instr_retired !== 32'd0 || cycle_count !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_lw_counters: retired=%0d cycles=%0d, expected 0 0", instr_retired, cycle_count);
        end
`endif
        waitrequest = 1'b0;
        run_instr(6'h3F, 6'($urandom), 0, 0, 0, 1'b0, "unknown_3f");
    endtask

    task automatic test_random();
        logic [5:0] ops[$] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                               6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                               6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h20, 6'h22,
                               6'h2B, 6'h28, 6'h02, 6'h04, 6'h3F, 6'h00};
        logic [5:0] fns[$] = '{6'h21, 6'h24, 6'h25, 6'h26, 6'h23, 6'h2A, 6'h2B, 6'h00, 6'h04,
                               6'h02, 6'h06, 6'h03, 6'h07, 6'h08, 6'h18, 6'h19, 6'h1A, 6'h1B,
                               6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                               6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h3F};
        int k;
        logic [5:0] fn;
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, ops.size() - 1);
            fn = (ops[k] == 6'h00) ? fns[k] : 6'($urandom);
            run_instr(ops[k], fn, $urandom_range(0, 4), $urandom_range(0, 4),
                      $urandom_range(0, 6), 1'b0, "random");
        end
        run_instr(6'h23, 6'h00, 1, 2, 0, 1'b1, "lw_ret_zero");
        apply_reset();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_jr_halt();
        test_watchdog();
        test_reset_mid_lw();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
